msx_mouse_port: RTL and testbench



---
 rtl/msx_mouse_pkg.sv | 28 ++
 rtl/sat_acc8.sv | 46 ++++
 rtl/msx_mouse_port.sv | 158 +++++++++++++++
 tb/tb_msx_mouse_port.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_mouse_pkg.sv
// Shared definitions for the MSX mouse port.
//   - phase encodings for the nibble read sequence (also exported on phase_o)
//   - default strobe timeout in clk cycles
//   - sat8: 8-bit signed add with clamping to [-128, +127]
package msx_mouse_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_XH   = 3'd1;
  localparam logic [2:0] ST_XL   = 3'd2;
  localparam logic [2:0] ST_YH   = 3'd3;
  localparam logic [2:0] ST_YL   = 3'd4;

  // About 1.5 ms at 21.48 MHz.
  localparam int unsigned TIMEOUT_DEFAULT = 32'd32000;

  // Add in 9 bits. Overflow shows up as a mismatch between the two top bits,
  // and bit 8 gives the true sign of the result.
  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum[8] != sum[7]) begin
      sat8 = sum[8] ? 8'h80 : 8'h7F;
    end else begin
      sat8 = sum[7:0];
    end
  endfunction

endpackage

// File: rtl/sat_acc8.sv
// 8-bit signed saturating accumulator.
//   clk, reset  : system clock, synchronous active-high reset
//   delta       : signed increment, two's complement
//   add_valid   : add delta this cycle
//   snap        : hand out the current value and restart the sum
//   acc_o       : current accumulated value (old value during a snap cycle)
// On a snap cycle the new value is delta if add_valid, otherwise 0, so a
// delta that lands on the snapshot goes into the next read.
module sat_acc8
  import msx_mouse_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] delta,
  input  logic       add_valid,
  input  logic       snap,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // Next accumulator value: restart on snap, otherwise saturating add.
  always_comb begin
    acc_d = acc_q;
    if (snap) begin
      acc_d = add_valid ? delta : 8'h00;
    end else if (add_valid) begin
      acc_d = sat8(acc_q, delta);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/msx_mouse_port.sv
// MSX mouse port sequencer.
// Accumulates signed X/Y deltas from a PS/2 mouse decoder and serves them to
// the MSX host as four nibbles (XH, XL, YH, YL), stepping on every toggle of
// the host strobe (pin 8). The first toggle of a read snapshots both
// accumulators. A quiet strobe for TIMEOUT_CYCLES returns the port to idle.
//   clk, reset         : system clock, synchronous active-high reset
//   dx, dx_valid       : signed X delta and its one-cycle add strobe
//   dy, dy_valid       : signed Y delta and its one-cycle add strobe
//   btn_l_n, btn_r_n   : mouse buttons, active-low
//   strobe             : host pin 8, asynchronous
//   nibble_o           : data to joystick pins 1-4
//   trig_a_n, trig_b_n : registered buttons
//   phase_o            : current sequence phase, for debug
module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dx,
  input  logic       dx_valid,
  input  logic [7:0] dy,
  input  logic       dy_valid,
  input  logic       btn_l_n,
  input  logic       btn_r_n,
  input  logic       strobe,
  output logic [3:0] nibble_o,
  output logic       trig_a_n,
  output logic       trig_b_n,
  output logic [2:0] phase_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   strobe_edge_s;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             lat_x_q, lat_x_d;
  logic [7:0]             lat_y_q, lat_y_d;
  logic                   trig_a_q, trig_a_d;
  logic                   trig_b_q, trig_b_d;
  logic                   snap_s;
  logic [7:0]             acc_x_s, acc_y_s;

  // Strobe synchroniser shift and history of the last stage; both strobe
  // polarities count as a step.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], strobe};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  assign strobe_edge_s = sync_q[SYNC_STAGES-1] ^ hist_q;

  // Sequence stepping; an edge takes priority over an expiring timeout.
  always_comb begin
    state_d = state_q;
    snap_s  = 1'b0;
    if (strobe_edge_s) begin
      case (state_q)
        ST_IDLE: begin state_d = ST_XH; snap_s = 1'b1; end
        ST_XH:   state_d = ST_XL;
        ST_XL:   state_d = ST_YH;
        ST_YH:   state_d = ST_YL;
        ST_YL:   begin state_d = ST_XH; snap_s = 1'b1; end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (cnt_q == CNT_EXPIRE)) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Quiet-strobe counter: held at zero in idle and on each edge, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (strobe_edge_s || (state_q == ST_IDLE)) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Snapshot latches and button pass-through.
  always_comb begin
    lat_x_d  = snap_s ? acc_x_s : lat_x_q;
    lat_y_d  = snap_s ? acc_y_s : lat_y_q;
    trig_a_d = btn_l_n;
    trig_b_d = btn_r_n;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{1'b0}};
      hist_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      lat_x_q  <= 8'h00;
      lat_y_q  <= 8'h00;
      trig_a_q <= 1'b1;
      trig_b_q <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_x_q  <= lat_x_d;
      lat_y_q  <= lat_y_d;
      trig_a_q <= trig_a_d;
      trig_b_q <= trig_b_d;
    end
  end

  sat_acc8 u_acc_x (
    .clk      (clk),
    .reset    (reset),
    .delta    (dx),
    .add_valid(dx_valid),
    .snap     (snap_s),
    .acc_o    (acc_x_s)
  );

  sat_acc8 u_acc_y (
    .clk      (clk),
    .reset    (reset),
    .delta    (dy),
    .add_valid(dy_valid),
    .snap     (snap_s),
    .acc_o    (acc_y_s)
  );

  // Nibble selection from the current phase and the snapshot.
  always_comb begin
    nibble_o = 4'h0;
    case (state_q)
      ST_IDLE: nibble_o = 4'h0;
      ST_XH:   nibble_o = lat_x_q[7:4];
      ST_XL:   nibble_o = lat_x_q[3:0];
      ST_YH:   nibble_o = lat_y_q[7:4];
      ST_YL:   nibble_o = lat_y_q[3:0];
      default: nibble_o = 4'h0;
    endcase
  end

  assign trig_a_n = trig_a_q;
  assign trig_b_n = trig_b_q;
  assign phase_o  = state_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
module tb_msx_mouse_port;

  localparam int T = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dx = 8'h00;
  logic       dx_valid = 1'b0;
  logic [7:0] dy = 8'h00;
  logic       dy_valid = 1'b0;
  logic       btn_l_n = 1'b1;
  logic       btn_r_n = 1'b1;
  logic       strobe = 1'b0;
  logic [3:0] nibble_o;
  logic       trig_a_n;
  logic       trig_b_n;
  logic [2:0] phase_o;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model: phase 0=idle, 1..4 = XH, XL, YH, YL.
  int m_phase = 0;
  int m_accx = 0, m_accy = 0, m_latx = 0, m_laty = 0;
  int m_quiet = 0;
  bit samp[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  bit m_ta = 1'b1, m_tb = 1'b1;

  msx_mouse_port #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .dx(dx), .dx_valid(dx_valid), .dy(dy), .dy_valid(dy_valid),
    .btn_l_n(btn_l_n), .btn_r_n(btn_r_n), .strobe(strobe), .nibble_o(nibble_o),
    .trig_a_n(trig_a_n), .trig_b_n(trig_b_n), .phase_o(phase_o)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic logic [3:0] exp_nibble();
    logic [7:0] lx, ly;
    lx = m_latx[7:0];
    ly = m_laty[7:0];
    case (m_phase)
      1: return lx[7:4];
      2: return lx[3:0];
      3: return ly[7:4];
      4: return ly[3:0];
      default: return 4'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the model: the strobe is seen two samples late, and a change
  // between those delayed samples is a step of the read sequence.
  task automatic model_step();
    bit e, snap;
    int sdx, sdy;
    if (reset) begin
      m_phase = 0; m_accx = 0; m_accy = 0; m_latx = 0; m_laty = 0; m_quiet = 0;
      samp = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_ta = 1'b1; m_tb = 1'b1;
    end else begin
      samp[3] = samp[2]; samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = strobe;
      e = (samp[2] != samp[3]);
      snap = e && (m_phase == 0 || m_phase == 4);
      if (e) begin
        m_phase = (m_phase == 4) ? 1 : m_phase + 1;
        m_quiet = 0;
      end else if (m_phase != 0) begin
        if (m_quiet == T - 1) begin
          m_phase = 0;
          m_quiet = 0;
        end else begin
          m_quiet++;
        end
      end else begin
        m_quiet = 0;
      end
      if (snap) begin
        m_latx = m_accx; m_laty = m_accy; m_accx = 0; m_accy = 0;
      end
      sdx = $signed(dx);
      sdy = $signed(dy);
      if (dx_valid) m_accx = clamp(m_accx + sdx);
      if (dy_valid) m_accy = clamp(m_accy + sdy);
      m_ta = btn_l_n; m_tb = btn_r_n;
    end
  endtask

  // Advance one clock, update the model, compare every output.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("nibble_o", {4'h0, nibble_o}, {4'h0, exp_nibble()});
    chk("phase_o", {5'h0, phase_o}, m_phase[7:0]);
    chk("trig_a_n", {7'h0, trig_a_n}, {7'h0, m_ta});
    chk("trig_b_n", {7'h0, trig_b_n}, {7'h0, m_tb});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_dx(input logic [7:0] v);
    dx = v; dx_valid = 1'b1; tick(); dx_valid = 1'b0;
  endtask

  task automatic pulse_dy(input logic [7:0] v);
    dy = v; dy_valid = 1'b1; tick(); dy_valid = 1'b0;
  endtask

  // Toggle the strobe and run until the step has taken effect.
  task automatic toggle_wait();
    strobe = ~strobe;
    idle(3);
  endtask

  task automatic read4(input logic [3:0] e0, input logic [3:0] e1,
                       input logic [3:0] e2, input logic [3:0] e3, input int gap);
    logic [3:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < 4; k++) begin
      toggle_wait();
      chk("read_nibble", {4'h0, nibble_o}, {4'h0, e[k]});
      idle(gap);
    end
  endtask

  initial begin
    // Reset state
    idle(3);
    reset = 1'b0;
    tick();
    chk("rst_nibble", {4'h0, nibble_o}, 8'h00);
    chk("rst_phase", {5'h0, phase_o}, 8'h00);
    chk("rst_trig_a", {7'h0, trig_a_n}, 8'h01);
    chk("rst_trig_b", {7'h0, trig_b_n}, 8'h01);

    // Basic read: X=+5, Y=-3
    pulse_dx(8'h05);
    pulse_dy(8'hFD);
    idle(5);
    chk("pre_read_nibble", {4'h0, nibble_o}, 8'h00);
    read4(4'h0, 4'h5, 4'hF, 4'hD, 100);
    chk("model_acc_x_zero", m_accx[7:0], 8'h00);
    chk("model_acc_y_zero", m_accy[7:0], 8'h00);
    idle(T + 5);

    // Saturation
    for (int i = 0; i < 3; i++) pulse_dx(8'h64);
    for (int i = 0; i < 3; i++) pulse_dy(8'h9C);
    read4(4'h7, 4'hF, 4'h8, 4'h0, 10);
    idle(T + 5);

    // Timeout from XL
    toggle_wait();
    toggle_wait();
    chk("to_phase_xl", {5'h0, phase_o}, 8'h02);
    idle(T - 1);
    chk("to_before_expiry", {5'h0, phase_o}, 8'h02);
    tick();
    chk("to_expired_phase", {5'h0, phase_o}, 8'h00);
    chk("to_expired_nibble", {4'h0, nibble_o}, 8'h00);
    pulse_dx(8'h09);
    read4(4'h0, 4'h9, 4'h0, 4'h0, 0);
    // Edge exactly on the expiry cycle keeps the sequence going
    toggle_wait();
    toggle_wait();
    idle(T - 3);
    toggle_wait();
    chk("edge_on_expiry_phase", {5'h0, phase_o}, 8'h03);
    idle(T + 5);

    // Delta coincident with the snapshot edge
    pulse_dx(8'h02);
    strobe = ~strobe;
    idle(2);
    dx = 8'h07; dx_valid = 1'b1;
    tick();
    dx_valid = 1'b0;
    chk("coin_phase_xh", {5'h0, phase_o}, 8'h01);
    toggle_wait();
    chk("coin_xl_old", {4'h0, nibble_o}, 8'h02);
    toggle_wait();
    toggle_wait();
    read4(4'h0, 4'h7, 4'h0, 4'h0, 0);
    idle(T + 5);

    // Back-to-back reads with a delta injected during the first
    pulse_dx(8'h04);
    toggle_wait();
    chk("b2b_xh", {4'h0, nibble_o}, 8'h00);
    pulse_dx(8'h01);
    toggle_wait();
    chk("b2b_xl", {4'h0, nibble_o}, 8'h04);
    toggle_wait();
    toggle_wait();
    read4(4'h0, 4'h1, 4'h0, 4'h0, 0);
    idle(T + 5);

    // Buttons
    btn_l_n = 1'b0;
    tick();
    chk("btn_l", {7'h0, trig_a_n}, 8'h00);
    chk("btn_r_idle", {7'h0, trig_b_n}, 8'h01);
    btn_r_n = 1'b0;
    tick();
    chk("btn_r", {7'h0, trig_b_n}, 8'h00);
    btn_l_n = 1'b1; btn_r_n = 1'b1;
    tick();

    // Reset in the middle of a read (state YH)
    pulse_dx(8'h12);
    pulse_dy(8'h34);
    toggle_wait();
    toggle_wait();
    toggle_wait();
    chk("mid_phase_yh", {5'h0, phase_o}, 8'h03);
    chk("mid_nibble_yh", {4'h0, nibble_o}, 8'h03);
    pulse_dx(8'h11);
    btn_l_n = 1'b0;
    reset = 1'b1;
    strobe = 1'b0;
    tick();
    chk("mid_rst_phase", {5'h0, phase_o}, 8'h00);
    chk("mid_rst_nibble", {4'h0, nibble_o}, 8'h00);
    chk("mid_rst_trig_a", {7'h0, trig_a_n}, 8'h01);
    chk("mid_rst_trig_b", {7'h0, trig_b_n}, 8'h01);
    reset = 1'b0;
    btn_l_n = 1'b1;
    idle(3);
    read4(4'h0, 4'h0, 4'h0, 4'h0, 2);
    idle(T + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
